prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, 16, instruction memory word-address width.
REQ-002 Parameter: DATA_W, 32, instruction word width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: start_i  input  1  one-cycle pulse that begins a load; sampled only in IDLE.
REQ-006 Port: base_addr_i  input  ADDR_W  first word address, captured on start_i.
REQ-007 Port: len_i  input  ADDR_W+1  word count (1..65536), captured on start_i.
REQ-008 Port: data_valid_i  input  1  stream word present.
REQ-009 Port: data_i  input  DATA_W  stream word.
REQ-010 Port: data_ready_o  output  1  loader accepts a word; transfer when valid&ready.
REQ-011 Port: mem_a_o  output  ADDR_W  memory word address.
REQ-012 Port: mem_w_o  output  1  memory write enable.
REQ-013 Port: mem_d_o  output  DATA_W  memory write data.
REQ-014 Port: mem_q_i  input  DATA_W  memory read data, valid one cycle after mem_a_o.
REQ-015 Port: core_rst_o  output  1  active-low reset to the core; 0 while not DONE.
REQ-016 Port: busy_o  output  1  high in LOAD or VERIFY.
REQ-017 Port: done_o  output  1  high in DONE.
REQ-018 Port: err_o  output  1  high in ERR.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, VERIFY, DONE, ERR.
REQ-020 IDLE->LOAD on start_i; len_i==0 SHALL be treated as 65536 words.
REQ-021 In LOAD, data_ready_o SHALL be 1; each transfer SHALL drive mem_w_o=1, mem_a_o=addr, mem_d_o=data_i in that same cycle (combinational pass-through).
REQ-022 Address SHALL increment modulo 2^ADDR_W after each transfer; wrap from 0xFFFF to 0x0000 is legal.
REQ-023 LOAD SHALL accumulate sum_w = sum_w + data_i (mod 2^32) per transfer; stalls (valid=0) add nothing and hold state.
REQ-024 After the last transfer, LOAD->VERIFY; address reloads base_addr.
REQ-025 VERIFY SHALL issue one read per cycle (mem_w_o=0), len reads total, and sum mem_q_i one cycle after each address into sum_r; data_ready_o=0.
REQ-026 One cycle after the final read, sum_r==sum_w SHALL go to DONE, else ERR.
REQ-027 DONE SHALL release core_rst_o=1; DONE and ERR SHALL return to IDLE only on start_i (restarting a load, core_rst_o=0 again from the next cycle).
REQ-028 start_i outside IDLE/DONE/ERR SHALL be ignored.
REQ-029 mem_w_o SHALL be 0 in every state except LOAD transfer cycles.
REQ-030 Total latency from last LOAD transfer to done_o SHALL be len+2 cycles.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, core_rst_o=0, data_ready_o=0, mem_w_o=0, mem_a_o=0, mem_d_o=0, busy_o=0, done_o=0, err_o=0, sums and counters 0.
REQ-032 Reset mid-LOAD or mid-VERIFY SHALL abandon the operation with no further memory writes; memory contents are not restored.

Structure
REQ-033 State encoding and ADDR_W/DATA_W defaults SHALL live in a shared package loader_pkg.
REQ-034 One sub-module, loader_cksum (clear/enable 32-bit modular accumulator), SHALL be instantiated twice (write and read sums).
REQ-035 The memory write port connects to the DP_mem32x64k instance the core reads from; arbitration is outside this block.

Verification
REQ-036 base=0x0010, len=4, words 1,2,3,4 back-to-back -> writes at 0x10..0x13, done_o after 6 more cycles, core_rst_o=1.
REQ-037 Same load with valid deasserted every other cycle -> identical memory contents and sums, done_o reached.
REQ-038 base=0xFFFE, len=4 -> writes at 0xFFFE,0xFFFF,0x0000,0x0001; done_o=1.
REQ-039 Memory model corrupts read at base+2 (bit 0 flipped) -> err_o=1, core_rst_o stays 0.
REQ-040 rst asserted after 2 of 4 transfers -> all outputs reset immediately, no mem_w_o afterwards; new start_i completes normally.
REQ-041 start_i pulsed during LOAD -> ignored; count and addresses unchanged.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: width defaults, FSM state
// encoding and a small state-classification helper.
package loader_pkg;

    // Default instruction memory geometry (64k words of 32 bits).
    localparam int unsigned LOADER_ADDR_W = 16;
    localparam int unsigned LOADER_DATA_W = 32;

    // FSM state encoding.
    localparam int unsigned ST_W      = 3;
    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_LOAD   = 3'd1;
    localparam logic [2:0]  ST_VERIFY = 3'd2;
    localparam logic [2:0]  ST_DONE   = 3'd3;
    localparam logic [2:0]  ST_ERR    = 3'd4;

    // True in the states that accept a start pulse (IDLE and both terminal states).
    function automatic logic can_launch(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERR);
    endfunction

endpackage

// File: rtl/loader_cksum.sv
// Modular checksum accumulator with synchronous clear and enable.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - synchronous clear to zero (wins over en)
//   en        - add din into the running sum this cycle
//   din       - word to accumulate
//   sum       - registered running sum, modulo 2^W
module loader_cksum #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    // Accumulator register; the natural W-bit wrap gives the modulo behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a block of instruction words into the core's
// instruction memory, reads the block back to verify a write/read checksum,
// and only then releases the core from reset.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   start_i         - start pulse (honoured in IDLE, DONE, ERR)
//   base_addr_i     - first word address of the block
//   len_i           - word count, 0 means 2^ADDR_W words
//   data_valid_i    - stream word present
//   data_i          - stream word
//   data_ready_o    - loader accepts a stream word (LOAD only)
//   mem_a_o         - memory word address
//   mem_w_o         - memory write enable (same-cycle pass-through of a transfer)
//   mem_d_o         - memory write data
//   mem_q_i         - memory read data, one cycle after mem_a_o
//   core_rst_o      - active-low core reset, released only in DONE
//   busy_o          - LOAD or VERIFY in progress
//   done_o          - verified successfully
//   err_o           - checksum mismatch
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = LOADER_ADDR_W,
    parameter int unsigned DATA_W = LOADER_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              data_ready_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_w_o,
    output logic [DATA_W-1:0] mem_d_o,
    input  logic [DATA_W-1:0] mem_q_i,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_m1_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              rd_done_q;
    logic              rd_pend_q;

    logic [DATA_W-1:0] sum_w;
    logic [DATA_W-1:0] sum_r;

    logic              launch_c;
    logic              accept_c;
    logic              last_wr_c;
    logic              issue_rd_c;
    logic              last_rd_c;
    logic              acc_rd_c;
    logic [DATA_W-1:0] verify_sum_c;

    // Handshake and terminal-count decodes.
    assign launch_c     = start_i && can_launch(state);
    assign accept_c     = (state == ST_LOAD) && data_valid_i;
    assign last_wr_c    = accept_c && (cnt_q == len_m1_q);
    assign issue_rd_c   = (state == ST_VERIFY) && !rd_done_q;
    assign last_rd_c    = issue_rd_c && (cnt_q == len_m1_q);
    assign acc_rd_c     = (state == ST_VERIFY) && rd_pend_q;

    // In the cycle after the final read the last word is still on mem_q_i,
    // so the comparison uses the sum including it.
    assign verify_sum_c = sum_r + mem_q_i;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_wr_c) begin
                    state_nxt = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (rd_done_q) begin
                    state_nxt = (verify_sum_c == sum_w) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address/count datapath. The count is reused for the read-back pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            addr_q    <= '0;
            len_m1_q  <= '0;
            cnt_q     <= '0;
            rd_done_q <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= issue_rd_c;
            if (launch_c) begin
                base_q    <= base_addr_i;
                addr_q    <= base_addr_i;
                // len_i==0 truncates to all-ones, i.e. 2^ADDR_W words.
                len_m1_q  <= ADDR_W'(len_i - LEN_W'(1));
                cnt_q     <= '0;
                rd_done_q <= 1'b0;
            end else if (accept_c) begin
                if (last_wr_c) begin
                    addr_q <= base_q;
                    cnt_q  <= '0;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                    cnt_q  <= cnt_q + ADDR_W'(1);
                end
            end else if (issue_rd_c) begin
                addr_q <= addr_q + ADDR_W'(1);
                cnt_q  <= cnt_q + ADDR_W'(1);
                if (last_rd_c) begin
                    rd_done_q <= 1'b1;
                end
            end
        end
    end

    // Status flags registered from the next state so they align with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rst_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            core_rst_o <= (state_nxt == ST_DONE);
            busy_o     <= (state_nxt == ST_LOAD) || (state_nxt == ST_VERIFY);
            done_o     <= (state_nxt == ST_DONE);
            err_o      <= (state_nxt == ST_ERR);
        end
    end

    // Write port is a same-cycle pass-through of the stream handshake.
    assign data_ready_o = (state == ST_LOAD);
    assign mem_w_o      = accept_c;
    assign mem_d_o      = accept_c ? data_i : '0;
    assign mem_a_o      = addr_q;

    // Sum of words written during LOAD.
    loader_cksum #(
        .W   (DATA_W)
    ) u_sum_w (
        .clk (clk),
        .rst (rst),
        .clr (launch_c),
        .en  (accept_c),
        .din (data_i),
        .sum (sum_w)
    );

    // Sum of words read back during VERIFY (data lags address by one cycle).
    loader_cksum #(
        .W   (DATA_W)
    ) u_sum_r (
        .clk (clk),
        .rst (rst),
        .clr (launch_c),
        .en  (acc_rd_c),
        .din (mem_q_i),
        .sum (sum_r)
    );

endmodule
